core_ex_trap: RTL and testbench

- Trap/return commit controller; the writer side of the CSR unit's commit-update port (cmt_mstatus/cmt_mcause/cmt_mepc).
- Accepts one exception or MRET request from EX and waits for outstanding LSU traffic to drain.
- Pulses the CSR commit writes, then holds a redirect/flush request to the IFU until it is accepted.
- Sits between EX/decode and the CSR unit plus IFU; machine mode only.

---
 rtl/core_ex_trap_pkg.sv | 28 ++
 rtl/core_ex_trap_if.sv | 38 +++
 rtl/core_ex_trap.sv | 158 +++++++++++++++
 tb/tb_core_ex_trap.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ex_trap_pkg.sv
// rtl/core_ex_trap_pkg.sv - trap/return controller types, cause codes and mstatus bit positions
package core_ex_trap_pkg;

    localparam int CORE_XLEN_DEF = 32;

    // Controller FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_FLUSH  = 2'd3
    } trap_state_e;

    // Machine-mode exception codes produced by EX
    localparam logic [3:0] CAUSE_IADDR_MISALIGN = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL_INSN   = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT     = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ECALL_M        = 4'd11;

    // mstatus field positions
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/core_ex_trap_if.sv
// rtl/core_ex_trap_if.sv - EX request and IFU redirect handshakes (CORE_TRAP_MTVAL_EN adds trap_tval)
interface core_ex_trap_if #(
    parameter int XLEN = 32
);
    logic            trap_valid;
    logic            trap_ready;
    logic            trap_mret;
    logic [3:0]      trap_cause;
    logic [XLEN-1:0] trap_pc;
`ifdef CORE_TRAP_MTVAL_EN
    logic [XLEN-1:0] trap_tval;
`endif
    logic            flush_valid;
    logic            flush_ready;
    logic [XLEN-1:0] flush_pc;

    // EX/IFU side: raises requests, consumes redirects
    modport master (
        output trap_valid, trap_mret, trap_cause, trap_pc,
`ifdef CORE_TRAP_MTVAL_EN
        output trap_tval,
`endif
        input  trap_ready,
        input  flush_valid, flush_pc,
        output flush_ready
    );

    // Trap controller side
    modport slave (
        input  trap_valid, trap_mret, trap_cause, trap_pc,
`ifdef CORE_TRAP_MTVAL_EN
        input  trap_tval,
`endif
        output trap_ready,
        output flush_valid, flush_pc,
        input  flush_ready
    );
endinterface

// File: rtl/core_ex_trap.sv
// rtl/core_ex_trap.sv - trap/MRET commit controller driving CSR commit port and IFU flush (option CORE_TRAP_MTVAL_EN)
module core_ex_trap
    import core_ex_trap_pkg::*;
#(
    parameter int XLEN = CORE_XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    core_ex_trap_if.slave   tif,
    input  logic            lsu_busy,
    input  logic [XLEN-1:0] csr_mstatus_r,
    input  logic [XLEN-1:0] csr_mtvec_r,
    input  logic [XLEN-1:0] csr_mepc_r,
    output logic            cmt_mstatus_en,
    output logic [XLEN-1:0] cmt_mstatus,
    output logic            cmt_mcause_en,
    output logic [XLEN-1:0] cmt_mcause,
    output logic            cmt_mepc_en,
    output logic [XLEN-1:0] cmt_mepc,
`ifdef CORE_TRAP_MTVAL_EN
    output logic            cmt_mtval_en,
    output logic [XLEN-1:0] cmt_mtval,
`endif
    output logic            trap_busy
);

    trap_state_e     state_q, state_d;
    logic            mret_q;
    logic [3:0]      cause_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] flush_pc_q;
    logic [XLEN-1:0] flush_target;
    logic            accept;
`ifdef CORE_TRAP_MTVAL_EN
    logic [XLEN-1:0] tval_q;
`endif

    // Low address bits are forced to zero on every target, so they are never read
    logic unused_low_bits;
    assign unused_low_bits = ^{pc_q[1:0], csr_mtvec_r[1:0], csr_mepc_r[1:0]};

    assign accept = tif.trap_valid && (state_q == ST_IDLE);

    // State register; reset abandons any in-flight request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_d         = state_q;
        tif.trap_ready  = 1'b0;
        tif.flush_valid = 1'b0;
        trap_busy       = 1'b1;
        case (state_q)
            ST_IDLE: begin
                tif.trap_ready = 1'b1;
                trap_busy      = 1'b0;
                if (tif.trap_valid) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!lsu_busy) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                tif.flush_valid = 1'b1;
                if (tif.flush_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the request at accept so EX is free to move on
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mret_q  <= 1'b0;
            cause_q <= 4'd0;
            pc_q    <= '0;
        end else if (accept) begin
            mret_q  <= tif.trap_mret;
            cause_q <= tif.trap_cause;
            pc_q    <= tif.trap_pc;
        end
    end

`ifdef CORE_TRAP_MTVAL_EN
    // Faulting address/instruction captured alongside the request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tval_q <= '0;
        end else if (accept) begin
            tval_q <= tif.trap_tval;
        end
    end
`endif

    // Redirect target: handler base for exceptions, saved mepc for MRET (vectored mode unsupported)
    always_comb begin
        flush_target = '0;
        if (mret_q) begin
            flush_target = {csr_mepc_r[XLEN-1:2], 2'b00};
        end else begin
            flush_target = {csr_mtvec_r[XLEN-1:2], 2'b00};
        end
    end

    // Target is frozen in COMMIT so it stays stable while the IFU back-pressures
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_pc_q <= '0;
        end else if (state_q == ST_COMMIT) begin
            flush_pc_q <= flush_target;
        end
    end

    assign tif.flush_pc = flush_pc_q;

    // CSR commit strobes and data; live CSR values are sampled only during COMMIT
    always_comb begin
        cmt_mstatus_en = 1'b0;
        cmt_mstatus    = '0;
        cmt_mcause_en  = 1'b0;
        cmt_mcause     = '0;
        cmt_mepc_en    = 1'b0;
        cmt_mepc       = '0;
`ifdef CORE_TRAP_MTVAL_EN
        cmt_mtval_en   = 1'b0;
        cmt_mtval      = '0;
`endif
        if (state_q == ST_COMMIT) begin
            cmt_mstatus_en = 1'b1;
            cmt_mstatus    = csr_mstatus_r;
            cmt_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
            if (mret_q) begin
                cmt_mstatus[MSTATUS_MIE]  = csr_mstatus_r[MSTATUS_MPIE];
                cmt_mstatus[MSTATUS_MPIE] = 1'b1;
            end else begin
                cmt_mstatus[MSTATUS_MPIE] = csr_mstatus_r[MSTATUS_MIE];
                cmt_mstatus[MSTATUS_MIE]  = 1'b0;
                cmt_mepc_en   = 1'b1;
                cmt_mepc      = {pc_q[XLEN-1:2], 2'b00};
                cmt_mcause_en = 1'b1;
                cmt_mcause    = {{(XLEN-4){1'b0}}, cause_q};
`ifdef CORE_TRAP_MTVAL_EN
                cmt_mtval_en  = 1'b1;
                cmt_mtval     = tval_q;
`endif
            end
        end
    end

endmodule

// File: tb/tb_core_ex_trap.sv
// tb/tb_core_ex_trap.sv - directed self-checking bench for core_ex_trap
module tb_core_ex_trap;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            lsu_busy;
    logic [XLEN-1:0] csr_mstatus_r;
    logic [XLEN-1:0] csr_mtvec_r;
    logic [XLEN-1:0] csr_mepc_r;
    logic            cmt_mstatus_en;
    logic [XLEN-1:0] cmt_mstatus;
    logic            cmt_mcause_en;
    logic [XLEN-1:0] cmt_mcause;
    logic            cmt_mepc_en;
    logic [XLEN-1:0] cmt_mepc;
`ifdef CORE_TRAP_MTVAL_EN
    logic            cmt_mtval_en;
    logic [XLEN-1:0] cmt_mtval;
`endif
    logic            trap_busy;

    int n_checks;
    int n_fail;

    core_ex_trap_if #(.XLEN(XLEN)) tif ();

    core_ex_trap #(.XLEN(XLEN)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tif            (tif),
        .lsu_busy       (lsu_busy),
        .csr_mstatus_r  (csr_mstatus_r),
        .csr_mtvec_r    (csr_mtvec_r),
        .csr_mepc_r     (csr_mepc_r),
        .cmt_mstatus_en (cmt_mstatus_en),
        .cmt_mstatus    (cmt_mstatus),
        .cmt_mcause_en  (cmt_mcause_en),
        .cmt_mcause     (cmt_mcause),
        .cmt_mepc_en    (cmt_mepc_en),
        .cmt_mepc       (cmt_mepc),
`ifdef CORE_TRAP_MTVAL_EN
        .cmt_mtval_en   (cmt_mtval_en),
        .cmt_mtval      (cmt_mtval),
`endif
        .trap_busy      (trap_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_no_strobe(input string tag);
        chk({tag, "_mstatus_en"}, 64'(cmt_mstatus_en), 64'd0);
        chk({tag, "_mcause_en"},  64'(cmt_mcause_en),  64'd0);
        chk({tag, "_mepc_en"},    64'(cmt_mepc_en),    64'd0);
`ifdef CORE_TRAP_MTVAL_EN
        chk({tag, "_mtval_en"},   64'(cmt_mtval_en),   64'd0);
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n            = 1'b0;
        lsu_busy         = 1'b0;
        csr_mstatus_r    = '0;
        csr_mtvec_r      = '0;
        csr_mepc_r       = '0;
        tif.trap_valid   = 1'b0;
        tif.trap_mret    = 1'b0;
        tif.trap_cause   = 4'd0;
        tif.trap_pc      = '0;
`ifdef CORE_TRAP_MTVAL_EN
        tif.trap_tval    = '0;
`endif
        tif.flush_ready  = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_ready",       64'(tif.trap_ready),  64'd1);
        chk("rst_busy",        64'(trap_busy),       64'd0);
        chk("rst_flush_valid", 64'(tif.flush_valid), 64'd0);
        chk("rst_flush_pc",    64'(tif.flush_pc),    64'd0);
        chk("rst_mstatus",     64'(cmt_mstatus),     64'd0);
        chk_no_strobe("rst");
        rst_n = 1'b1;

        // ecall, minimum latency, flush_ready already high
        csr_mstatus_r   = 32'h0000_0008;
        csr_mtvec_r     = 32'h8000_0200;
        csr_mepc_r      = 32'h1234_5678;
        tif.flush_ready = 1'b1;
        tif.trap_valid  = 1'b1;
        tif.trap_mret   = 1'b0;
        tif.trap_cause  = 4'd11;
        tif.trap_pc     = 32'h8000_0104;
        chk("ecall_ready_idle", 64'(tif.trap_ready), 64'd1);
        tick();
        tif.trap_valid = 1'b0;
        chk("ecall_drain_busy",  64'(trap_busy),      64'd1);
        chk("ecall_drain_ready", 64'(tif.trap_ready), 64'd0);
        chk_no_strobe("ecall_drain");
        tick();
        chk("ecall_mepc_en",    64'(cmt_mepc_en),     64'd1);
        chk("ecall_mepc",       64'(cmt_mepc),        64'h8000_0104);
        chk("ecall_mcause_en",  64'(cmt_mcause_en),   64'd1);
        chk("ecall_mcause",     64'(cmt_mcause),      64'd11);
        chk("ecall_mstatus_en", 64'(cmt_mstatus_en),  64'd1);
        chk("ecall_mstatus",    64'(cmt_mstatus),     64'h1880);
        chk("ecall_commit_fv",  64'(tif.flush_valid), 64'd0);
        tick();
        chk("ecall_flush_valid", 64'(tif.flush_valid), 64'd1);
        chk("ecall_flush_pc",    64'(tif.flush_pc),    64'h8000_0200);
        chk_no_strobe("ecall_flush");
        tick();
        chk("ecall_idle_ready", 64'(tif.trap_ready),  64'd1);
        chk("ecall_idle_fv",    64'(tif.flush_valid), 64'd0);

        // MRET, with the IFU stalling the redirect for 3 cycles
        tif.flush_ready = 1'b0;
        csr_mstatus_r   = 32'h0000_1880;
        csr_mepc_r      = 32'h8000_0108;
        tif.trap_valid  = 1'b1;
        tif.trap_mret   = 1'b1;
        tif.trap_cause  = 4'd5;
        tif.trap_pc     = 32'h8000_0040;
        tick();
        tif.trap_valid = 1'b0;
        tick();
        chk("mret_mstatus_en", 64'(cmt_mstatus_en), 64'd1);
        chk("mret_mstatus",    64'(cmt_mstatus),    64'h1888);
        chk("mret_mepc_en",    64'(cmt_mepc_en),    64'd0);
        chk("mret_mcause_en",  64'(cmt_mcause_en),  64'd0);
        chk("mret_mepc_data",  64'(cmt_mepc),       64'd0);
`ifdef CORE_TRAP_MTVAL_EN
        chk("mret_mtval_en",   64'(cmt_mtval_en),   64'd0);
`endif
        tick();
        // A new illegal-instruction request is held while the redirect waits
        tif.trap_valid = 1'b1;
        tif.trap_mret  = 1'b0;
        tif.trap_cause = 4'd2;
        tif.trap_pc    = 32'h8000_0aa2;
        csr_mstatus_r  = 32'h0000_0000;
        csr_mtvec_r    = 32'h8000_0301;
        for (int i = 0; i < 3; i++) begin
            chk("mret_stall_fv",    64'(tif.flush_valid), 64'd1);
            chk("mret_stall_pc",    64'(tif.flush_pc),    64'h8000_0108);
            chk("mret_stall_ready", 64'(tif.trap_ready),  64'd0);
            tick();
        end
        tif.flush_ready = 1'b1;
        chk("mret_last_fv", 64'(tif.flush_valid), 64'd1);
        chk("mret_last_pc", 64'(tif.flush_pc),    64'h8000_0108);
        tick();
        chk("held_ready_idle", 64'(tif.trap_ready),  64'd1);
        chk("held_idle_fv",    64'(tif.flush_valid), 64'd0);
        lsu_busy = 1'b1;
        tick();
        tif.trap_valid  = 1'b0;
        tif.flush_ready = 1'b0;

        // Illegal instruction: DRAIN held 5 cycles by LSU traffic
        for (int i = 0; i < 5; i++) begin
            chk("ill_drain_busy",  64'(trap_busy),      64'd1);
            chk("ill_drain_ready", 64'(tif.trap_ready), 64'd0);
            chk_no_strobe("ill_drain");
            if (i == 4) lsu_busy = 1'b0;
            tick();
        end
        chk("ill_mepc",    64'(cmt_mepc),       64'h8000_0aa0);
        chk("ill_mcause",  64'(cmt_mcause),     64'd2);
        chk("ill_mstatus", 64'(cmt_mstatus),    64'h1800);
        chk("ill_st_en",   64'(cmt_mstatus_en), 64'd1);
        chk("ill_ready",   64'(tif.trap_ready), 64'd0);
        tick();
        chk_no_strobe("ill_after_commit");
        chk("ill_flush_valid", 64'(tif.flush_valid), 64'd1);
        chk("ill_flush_pc",    64'(tif.flush_pc),    64'h8000_0300);
        chk("ill_flush_ready", 64'(tif.trap_ready),  64'd0);
        tif.flush_ready = 1'b1;
        tick();
        chk("ill_idle_ready", 64'(tif.trap_ready), 64'd1);

        // Reset during DRAIN aborts with no CSR write
        tif.flush_ready = 1'b0;
        lsu_busy        = 1'b1;
        tif.trap_valid  = 1'b1;
        tif.trap_cause  = 4'd3;
        tif.trap_pc     = 32'h0000_0100;
        tick();
        tif.trap_valid = 1'b0;
        chk("rd_busy", 64'(trap_busy), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        lsu_busy = 1'b0;
        chk("rd_ready", 64'(tif.trap_ready),  64'd1);
        chk("rd_busy0", 64'(trap_busy),       64'd0);
        chk("rd_fv",    64'(tif.flush_valid), 64'd0);
        chk_no_strobe("rd");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_no_strobe("rd_after");
            chk("rd_after_busy", 64'(trap_busy), 64'd0);
        end

        // Reset during FLUSH drops the redirect
        tif.trap_valid = 1'b1;
        tick();
        tif.trap_valid = 1'b0;
        tick();
        tick();
        chk("rf_pre_fv", 64'(tif.flush_valid), 64'd1);
        chk("rf_pre_pc", 64'(tif.flush_pc),    64'h8000_0300);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rf_fv",    64'(tif.flush_valid), 64'd0);
        chk("rf_pc",    64'(tif.flush_pc),    64'd0);
        chk("rf_ready", 64'(tif.trap_ready),  64'd1);
        chk_no_strobe("rf");

`ifdef CORE_TRAP_MTVAL_EN
        // Load misaligned carries tval into mtval
        tif.flush_ready = 1'b1;
        tif.trap_valid  = 1'b1;
        tif.trap_mret   = 1'b0;
        tif.trap_cause  = 4'd4;
        tif.trap_pc     = 32'h8000_0010;
        tif.trap_tval   = 32'h8000_1003;
        tick();
        tif.trap_valid = 1'b0;
        tif.trap_tval  = '0;
        tick();
        chk("mtval_en",     64'(cmt_mtval_en), 64'd1);
        chk("mtval",        64'(cmt_mtval),    64'h8000_1003);
        chk("mtval_mcause", 64'(cmt_mcause),   64'd4);
        tick();
        chk("mtval_en_off", 64'(cmt_mtval_en), 64'd0);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
